// File: rtl/pc_gen_pkg.sv
// Shared fetch-stage definitions: state encodings, default vectors and the
// step-alignment helper used by the program-counter generator.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    S_RST  = 2'd0,
    S_BOOT = 2'd1,
    S_RUN  = 2'd2,
    S_HALT = 2'd3
  } state_t;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_0020;
  localparam int          DEF_STEP      = 4;

  // log2 of a power-of-two step; gives the number of low target bits cleared
  function automatic int step_lsb(input int step);
    int n;
    n = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) == step) n = i;
    end
    return n;
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-stage bus between the program-counter generator and the pipeline.
// master: the PC generator side; slave: the pipeline/control side.
interface pc_gen_if #(
  parameter int ADDR_W = 32
);
  logic              stall;
  logic              br_taken;
  logic [ADDR_W-1:0] br_target;
  logic              exc_req;
  logic              halt_req;
  logic [ADDR_W-1:0] pc;
  logic              ce;
  logic              redirect;

  modport master (
    input  stall, br_taken, br_target, exc_req, halt_req,
    output pc, ce, redirect
  );

  modport slave (
    output stall, br_taken, br_target, exc_req, halt_req,
    input  pc, ce, redirect
  );
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator for instruction fetch. Next-pc mux and the
// sequencing FSM form a single register stage; every output is registered.
//
// state  | meaning
// S_RST  | in or just out of reset, ce low, requests ignored
// S_BOOT | one cycle presenting RESET_VEC with ce high
// S_RUN  | fetching: exception > branch > stall > sequential
// S_HALT | ce low, pc held; only an exception moves pc
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                STEP      = DEF_STEP,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC),
  parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(DEF_EXC_VEC)
) (
  input logic      clk,
  input logic      rst,
  pc_gen_if.master bus
);

  localparam int                STEP_LSB   = step_lsb(STEP);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << STEP_LSB;
  localparam logic [ADDR_W-1:0] STEP_INC   = ADDR_W'(STEP);

  state_t            state;
  logic [ADDR_W-1:0] pc_q;
  logic              ce_q;
  logic              redir_q;
  logic [ADDR_W-1:0] run_pc;
  logic              run_redir;

  // Priority-ordered next pc while running; redirects win over stall
  always_comb begin
    run_pc    = pc_q + STEP_INC;
    run_redir = 1'b0;
    if (bus.exc_req) begin
      run_pc    = EXC_VEC;
      run_redir = 1'b1;
    end else if (bus.br_taken) begin
      run_pc    = bus.br_target & ALIGN_MASK;
      run_redir = 1'b1;
    end else if (bus.stall) begin
      run_pc = pc_q;
    end
  end

  // Sequencing FSM with registered pc/ce/redirect
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_RST;
      pc_q    <= RESET_VEC;
      ce_q    <= 1'b0;
      redir_q <= 1'b0;
    end else begin
      case (state)
        S_RST: begin
          state   <= S_BOOT;
          ce_q    <= 1'b1;
          redir_q <= 1'b0;
        end
        S_BOOT: begin
          if (bus.halt_req) begin
            state   <= S_HALT;
            ce_q    <= 1'b0;
            redir_q <= 1'b0;
          end else begin
            state   <= S_RUN;
            pc_q    <= run_pc;
            redir_q <= run_redir;
          end
        end
        S_RUN: begin
          // the halting edge still takes its update so a redirect survives
          pc_q    <= run_pc;
          redir_q <= run_redir;
          if (bus.halt_req) begin
            state <= S_HALT;
            ce_q  <= 1'b0;
          end
        end
        S_HALT: begin
          if (bus.exc_req) begin
            pc_q    <= EXC_VEC;
            redir_q <= 1'b1;
          end else begin
            redir_q <= 1'b0;
          end
          // wake re-issues the held address as the first fetch
          if (!bus.halt_req) begin
            state <= S_RUN;
            ce_q  <= 1'b1;
          end
        end
        default: begin
          state   <= S_RST;
          ce_q    <= 1'b0;
          redir_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc       = pc_q;
  assign bus.ce       = ce_q;
  assign bus.redirect = redir_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed vector table, hand-written
// reset/wrap sequences, and random stimulus against a reference model.
module tb_pc_gen;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pc_gen_if #(.ADDR_W(32)) bus ();
  pc_gen_if #(.ADDR_W(8))  bus8 ();

  pc_gen #(.ADDR_W(32)) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  pc_gen #(.ADDR_W(8), .STEP(4)) u_dut8 (
    .clk(clk),
    .rst(rst),
    .bus(bus8)
  );

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        exc;
    logic        halt;
    logic [31:0] pc;
    logic        ce;
    logic        red;
  } vec_t;

  vec_t vecs[18];

  // reference model state
  longint unsigned m_pc;
  bit              m_ce;
  bit              m_red;
  bit              m_halted;
  int              m_edges;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic br, input logic [31:0] tgt,
                       input logic exc, input logic hlt);
    bus.stall     = st;
    bus.br_taken  = br;
    bus.br_target = tgt;
    bus.exc_req   = exc;
    bus.halt_req  = hlt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check3(input string tag, input logic [31:0] pc, input logic ce, input logic red);
    check({tag, ".pc"}, bus.pc, pc);
    check({tag, ".ce"}, {31'd0, bus.ce}, {31'd0, ce});
    check({tag, ".redirect"}, {31'd0, bus.redirect}, {31'd0, red});
  endtask

  task automatic model_reset();
    m_pc = 0; m_ce = 0; m_red = 0; m_halted = 0; m_edges = 0;
  endtask

  task automatic model_run(input bit st, input bit br, input longint unsigned tgt, input bit exc);
    if (exc) begin
      m_pc = 64'h20; m_red = 1;
    end else if (br) begin
      m_pc = (tgt / 4) * 4; m_red = 1;
    end else if (st) begin
      m_red = 0;
    end else begin
      m_pc = (m_pc + 4) % (64'd1 << 32); m_red = 0;
    end
  endtask

  // expected outputs after one rising edge with rst released
  task automatic model_edge(input bit st, input bit br, input longint unsigned tgt,
                            input bit exc, input bit hlt);
    if (m_edges == 0) begin
      m_ce = 1; m_red = 0;
    end else if (m_edges == 1) begin
      if (hlt) begin
        m_halted = 1; m_ce = 0; m_red = 0;
      end else begin
        model_run(st, br, tgt, exc);
      end
    end else if (!m_halted) begin
      model_run(st, br, tgt, exc);
      if (hlt) begin
        m_halted = 1; m_ce = 0;
      end
    end else begin
      m_red = exc;
      if (exc) m_pc = 64'h20;
      if (!hlt) begin
        m_halted = 0; m_ce = 1;
      end
    end
    m_edges++;
  endtask

  initial begin
    bit st, br, exc, hlt;
    logic [31:0] tgt;

    //         stall br  tgt           exc halt  pc            ce  red
    vecs[0]  = '{0, 0, 32'h0,        0, 0, 32'h0000_0000, 1, 0};
    vecs[1]  = '{0, 0, 32'h0,        0, 0, 32'h0000_0004, 1, 0};
    vecs[2]  = '{0, 0, 32'h0,        0, 0, 32'h0000_0008, 1, 0};
    vecs[3]  = '{1, 0, 32'h0,        0, 0, 32'h0000_0008, 1, 0};
    vecs[4]  = '{1, 0, 32'h0,        0, 0, 32'h0000_0008, 1, 0};
    vecs[5]  = '{1, 1, 32'h0000_1003, 0, 0, 32'h0000_1000, 1, 1};
    vecs[6]  = '{0, 0, 32'h0,        0, 0, 32'h0000_1004, 1, 0};
    vecs[7]  = '{0, 1, 32'h0000_0040, 1, 0, 32'h0000_0020, 1, 1};
    vecs[8]  = '{0, 0, 32'h0,        0, 0, 32'h0000_0024, 1, 0};
    vecs[9]  = '{0, 1, 32'h0000_0010, 0, 0, 32'h0000_0010, 1, 1};
    vecs[10] = '{0, 0, 32'h0,        0, 1, 32'h0000_0014, 0, 0};
    vecs[11] = '{0, 1, 32'h0000_0100, 0, 1, 32'h0000_0014, 0, 0};
    vecs[12] = '{1, 0, 32'h0,        0, 1, 32'h0000_0014, 0, 0};
    vecs[13] = '{0, 0, 32'h0,        1, 1, 32'h0000_0020, 0, 1};
    vecs[14] = '{0, 0, 32'h0,        0, 1, 32'h0000_0020, 0, 0};
    vecs[15] = '{0, 0, 32'h0,        0, 0, 32'h0000_0020, 1, 0};
    vecs[16] = '{0, 0, 32'h0,        0, 0, 32'h0000_0024, 1, 0};
    vecs[17] = '{0, 1, 32'h0000_0080, 0, 0, 32'h0000_0080, 1, 1};

    drive(0, 0, 0, 0, 0);
    bus8.stall = 0; bus8.br_taken = 0; bus8.br_target = 8'h0;
    bus8.exc_req = 0; bus8.halt_req = 0;

    // reset held for three cycles
    repeat (3) tick();
    check3("reset", 32'h0, 1'b0, 1'b0);
    rst = 1'b1;

    // directed table: boot, stall/branch, exception, halt/wake
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].stall, vecs[i].br, vecs[i].tgt, vecs[i].exc, vecs[i].halt);
      tick();
      check3($sformatf("vec%0d", i), vecs[i].pc, vecs[i].ce, vecs[i].red);
    end

    // asynchronous reset between edges while a branch is pending
    #2 rst = 1'b0;
    #1 check3("async_rst", 32'h0, 1'b0, 1'b0);
    repeat (2) tick();
    check3("rst_hold", 32'h0, 1'b0, 1'b0);
    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check3($sformatf("reboot%0d", i), vecs[i].pc, vecs[i].ce, vecs[i].red);
    end

    // wrap-around on the 8-bit instance (currently at 8'h08 after reboot)
    bus8.br_taken = 1; bus8.br_target = 8'hFF;
    tick();
    check("wrap.br_pc", {24'd0, bus8.pc}, 32'hFC);
    check("wrap.br_red", {31'd0, bus8.redirect}, 32'd1);
    bus8.br_taken = 0;
    tick();
    check("wrap.pc", {24'd0, bus8.pc}, 32'h00);
    check("wrap.red", {31'd0, bus8.redirect}, 32'd0);
    check("wrap.ce", {31'd0, bus8.ce}, 32'd1);
    tick();
    check("wrap.next", {24'd0, bus8.pc}, 32'h04);

    // random stimulus against the reference model, halt requested at boot
    rst = 1'b0;
    tick();
    check3("rnd_rst", 32'h0, 1'b0, 1'b0);
    model_reset();
    rst = 1'b1;
    hlt = 1;
    for (int c = 0; c < 400; c++) begin
      if (c > 3 && $urandom_range(0, 9) == 0) hlt = ~hlt;
      st  = ($urandom_range(0, 9) < 3);
      br  = ($urandom_range(0, 19) < 3);
      exc = ($urandom_range(0, 19) == 0);
      tgt = $urandom;
      if ($urandom_range(0, 4) == 0) tgt = 32'hFFFF_FFF0 | {28'd0, tgt[3:0]};
      drive(st, br, tgt, exc, hlt);
      model_edge(st, br, {32'd0, tgt}, exc, hlt);
      tick();
      check3($sformatf("rnd%0d", c), m_pc[31:0], m_ce, m_red);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
